// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, legality test
// and the control FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OpAdd        = 4'h0;
  localparam logic [3:0] OpSub        = 4'h1;
  localparam logic [3:0] OpAnd        = 4'h2;
  localparam logic [3:0] OpOr         = 4'h3;
  localparam logic [3:0] OpNot        = 4'h4;
  localparam logic [3:0] OpIllegalMin = 4'h5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op < OpIllegalMin;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with a
// round-robin grant and an IDLE -> EXEC -> RESP control sequence.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [7:0]            req_ctrl,
  input  logic [2*DATA_W-1:0]   req_x,
  input  logic [2*DATA_W-1:0]   req_y,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_carry,
  output logic                  resp_err,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_W-1:0]     alu_x,
  output logic [DATA_W-1:0]     alu_y,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_carry,
  output logic                  busy
);

  state_e state_q;
  logic   last_q;
  logic   owner_q;
  logic   ill_q;

  logic [1:0]        grant;
  logic              gidx;
  logic              hs;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_x;
  logic [DATA_W-1:0] sel_y;
  logic              sel_legal;

  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    req_ready = (state_q == StIdle) ? grant : 2'b00;
    hs        = |(req_valid & req_ready);
    gidx      = grant[1];
    sel_op    = gidx ? req_ctrl[7:4] : req_ctrl[3:0];
    sel_x     = gidx ? req_x[2*DATA_W-1:DATA_W] : req_x[DATA_W-1:0];
    sel_y     = gidx ? req_y[2*DATA_W-1:DATA_W] : req_y[DATA_W-1:0];
    sel_legal = op_legal(sel_op);
    busy      = (state_q != StIdle);
  end

  // last_q resets to 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      ill_q      <= 1'b0;
      alu_ctrl   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            state_q  <= StExec;
            last_q   <= gidx;
            owner_q  <= gidx;
            ill_q    <= !sel_legal;
            // Illegal ops still take a slot but present zeros to the ALU.
            alu_ctrl <= sel_legal ? sel_op : '0;
            alu_x    <= sel_legal ? sel_x : '0;
            alu_y    <= sel_legal ? sel_y : '0;
          end
        end
        StExec: begin
          state_q    <= StResp;
          resp_data  <= ill_q ? '0 : alu_out;
          resp_carry <= !ill_q && (alu_ctrl == OpAdd || alu_ctrl == OpSub) && alu_carry;
          resp_err   <= ill_q;
          resp_valid <= owner_q ? 2'b10 : 2'b01;
          alu_ctrl   <= '0;
          alu_x      <= '0;
          alu_y      <= '0;
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            state_q    <= StIdle;
            resp_valid <= 2'b00;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [7:0]  resp_data;
  logic        resp_carry;
  logic        resp_err;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic force_carry = 1'b0;
  logic mon_en = 1'b0;
  int hs_idx[$];
  int hs_t[$];

  alu_arbiter #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_carry (resp_carry),
    .resp_err   (resp_err),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; force_carry lets the bench drive a spurious carry on logic ops.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'h0: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'h1: {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'h2: begin alu_out = alu_x & alu_y; alu_carry = force_carry; end
      4'h3: begin alu_out = alu_x | alu_y; alu_carry = force_carry; end
      4'h4: begin alu_out = ~alu_x; alu_carry = force_carry; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && |(req_valid & req_ready)) begin
      hs_idx.push_back(req_ready[1] ? 1 : 0);
      hs_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, req_ready, resp_valid, resp_data, resp_carry, resp_err,
            alu_ctrl, alu_x, alu_y, busy};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle"}, {63'd0, busy}, 64'd0);
  endtask

  // Issue one op with resp_ready high and check EXEC drive and the response.
  task automatic run_op(input string tag, input int idx, input logic [3:0] op,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp_d,
                        input logic exp_c, input logic exp_e);
    logic legal;
    legal = (op < 4'h5);
    @(negedge clk);
    req_ctrl[idx*4 +: 4] = op;
    req_x[idx*8 +: 8]    = x;
    req_y[idx*8 +: 8]    = y;
    req_valid            = (idx == 1) ? 2'b10 : 2'b01;
    #1 check({tag, ".rdy"}, {62'd0, req_ready}, (idx == 1) ? 64'd2 : 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    check({tag, ".exec_busy"}, {63'd0, busy}, 64'd1);
    check({tag, ".exec_alu"}, {44'd0, alu_ctrl, alu_x, alu_y},
          legal ? {44'd0, op, x, y} : 64'd0);
    check({tag, ".exec_rv"}, {62'd0, resp_valid}, 64'd0);
    @(negedge clk);
    check({tag, ".resp"}, {52'd0, resp_valid, resp_data, resp_carry, resp_err},
          {52'd0, (idx == 1) ? 2'b10 : 2'b01, exp_d, exp_c, exp_e});
    @(negedge clk);
    check({tag, ".done"}, {62'd0, busy, resp_valid != 2'b00}, 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_ctrl   = 8'h00;
    req_x      = 16'h0000;
    req_y      = 16'h0000;
    resp_ready = 2'b11;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
    @(negedge clk);
    req_ctrl  = 8'h00;
    req_x     = 16'h0101;
    req_y     = 16'h0101;
    req_valid = 2'b11;
    mon_en    = 1'b1;
    repeat (11) @(negedge clk);
    mon_en    = 1'b0;
    req_valid = 2'b00;
    wait_idle("rr");
    check("rr.count", hs_idx.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_idx.size()) check($sformatf("rr.grant%0d", i), hs_idx[i], i % 2);
      if (i > 0 && i < hs_t.size())
        check($sformatf("rr.gap%0d", i), hs_t[i] - hs_t[i-1], 64'd3);
    end

    run_op("add_ff_01", 0, 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("sub_05_07", 1, 4'h1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
    force_carry = 1'b1;
    run_op("and_f0_3c", 1, 4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op("not_a5", 0, 4'h4, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0);
    force_carry = 1'b0;
    run_op("or_81_18", 1, 4'h3, 8'h81, 8'h18, 8'h99, 1'b0, 1'b0);
    run_op("illegal_a", 0, 4'hA, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);

    // Response stall: non-owner resp_ready ignored, waiting requester not granted.
    @(negedge clk);
    resp_ready = 2'b10;
    req_ctrl   = 8'h00;
    req_x      = 16'h0003;
    req_y      = 16'h0004;
    req_valid  = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d", i), {50'd0, resp_valid, resp_data, req_ready, busy,
            resp_carry}, {50'd0, 2'b01, 8'h07, 2'b00, 1'b1, 1'b0});
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b01;
    @(negedge clk);
    check("stall.release", {62'd0, busy, resp_valid != 2'b00}, 64'd0);
    resp_ready = 2'b11;

    // Leave requester 1 as preferred, then abort an op with reset mid-EXEC.
    run_op("pre_abort", 0, 4'h0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    req_ctrl  = 8'h00;
    req_x     = 16'h0055;
    req_y     = 16'h0066;
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    check("abort.in_exec", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1 check("abort.outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort.no_resp%0d", i), {62'd0, resp_valid}, 64'd0);
    end
    req_valid = 2'b11;
    #1 check("abort.grant0", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
